// File: rtl/whistle_detector.sv
// whistle_detector: counts hysteresis zero crossings per window and detects a held in-band tone.
// Define WHISTLE_AMP_GATE_EN to also require a minimum per-window peak magnitude.
module whistle_detector #(
   parameter int DATA_W          = 16,
   parameter int WIN_SAMPLES     = 1024,
   parameter int ZC_MIN          = 43,
   parameter int ZC_MAX          = 128,
   parameter int HYST            = 256,
   parameter int HOLD_WINDOWS    = 4,
   parameter int RELEASE_WINDOWS = 2,
   parameter int AMP_THRESH      = 2048
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 sample_valid,
   input  logic signed [DATA_W-1:0]             sample_data,
   output logic                                 window_done,
   output logic [$clog2(WIN_SAMPLES+1)-1:0]     zc_count_last,
   output logic                                 whistle_detected,
   output logic                                 whistle_active
);
   localparam int CW = $clog2(WIN_SAMPLES + 1);
   localparam int SW = $clog2(WIN_SAMPLES);
   localparam int RW = $clog2(HOLD_WINDOWS + 1);
   localparam int MW = $clog2(RELEASE_WINDOWS + 1);
   localparam logic signed [DATA_W-1:0] POS_T = DATA_W'(HYST);
   localparam logic signed [DATA_W-1:0] NEG_T = DATA_W'(-HYST);
   localparam logic [SW-1:0] LAST_IDX = SW'(WIN_SAMPLES - 1);
   localparam logic [CW-1:0] ZMIN = CW'(ZC_MIN);
   localparam logic [CW-1:0] ZMAX = CW'(ZC_MAX);
   localparam logic [RW-1:0] RUN_TOP = RW'(HOLD_WINDOWS - 1);
   localparam logic [MW-1:0] MISS_TOP = MW'(RELEASE_WINDOWS - 1);

   typedef enum logic [1:0] {SEARCH, CONFIRM, ACTIVE} state_t;

   state_t          state_q, state_d;
   logic            sign_valid_q, sign_q, done_q, det_q, det_d;
   logic [SW-1:0]   cnt_q;
   logic [CW-1:0]   zc_q, zc_last_q, zc_inc;
   logic [RW-1:0]   run_q, run_d;
   logic [MW-1:0]   miss_q, miss_d;
   logic            pos, neg, flip, last, qual_zc, qual;

   assign pos     = sample_data > POS_T;
   assign neg     = sample_data < NEG_T;
   assign flip    = sample_valid && sign_valid_q && ((pos && !sign_q) || (neg && sign_q));
   assign zc_inc  = zc_q + CW'(flip);
   assign last    = sample_valid && cnt_q == LAST_IDX;
   assign qual_zc = zc_inc >= ZMIN && zc_inc <= ZMAX;

`ifdef WHISTLE_AMP_GATE_EN
   localparam logic [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [DATA_W-1:0] MAX_V = ~MIN_V;
   logic [DATA_W-1:0] peak_q, mag, peak_nx;
   // The most negative code has no positive twin, so it clips to the largest magnitude.
   assign mag     = !sample_data[DATA_W-1] ? sample_data :
                    (sample_data == MIN_V ? MAX_V : -sample_data);
   assign peak_nx = (sample_valid && mag > peak_q) ? mag : peak_q;
   assign qual    = qual_zc && peak_nx >= DATA_W'(AMP_THRESH);
   always_ff @(posedge clk) begin
      if (rst || last) peak_q <= '0;
      else peak_q <= peak_nx;
   end
`else
   logic unused_amp;
   assign unused_amp = |AMP_THRESH;
   assign qual       = qual_zc;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= SEARCH;
         sign_valid_q <= 1'b0;
         sign_q       <= 1'b0;
         done_q       <= 1'b0;
         det_q        <= 1'b0;
         cnt_q        <= '0;
         zc_q         <= '0;
         zc_last_q    <= '0;
         run_q        <= '0;
         miss_q       <= '0;
      end else begin
         state_q <= state_d;
         done_q  <= last;
         det_q   <= det_d;
         run_q   <= run_d;
         miss_q  <= miss_d;
         if (sample_valid) begin
            if (pos || neg) begin
               sign_valid_q <= 1'b1;
               sign_q       <= pos;
            end
            cnt_q <= last ? '0 : cnt_q + 1'b1;
            zc_q  <= last ? '0 : zc_inc;
            if (last) zc_last_q <= zc_inc;
         end
      end
   end

   // Decisions use the closing sample's final count so they land with window_done.
   always_comb begin
      state_d = state_q;
      run_d   = run_q;
      miss_d  = miss_q;
      det_d   = 1'b0;
      if (last) begin
         case (state_q)
            SEARCH: if (qual) begin
               state_d = HOLD_WINDOWS == 1 ? ACTIVE : CONFIRM;
               det_d   = HOLD_WINDOWS == 1;
               run_d   = HOLD_WINDOWS == 1 ? '0 : RW'(1);
               miss_d  = '0;
            end
            CONFIRM: begin
               state_d = !qual ? SEARCH : (run_q == RUN_TOP ? ACTIVE : CONFIRM);
               det_d   = qual && run_q == RUN_TOP;
               run_d   = (qual && run_q != RUN_TOP) ? run_q + 1'b1 : '0;
               miss_d  = '0;
            end
            ACTIVE: begin
               state_d = (!qual && miss_q == MISS_TOP) ? SEARCH : ACTIVE;
               miss_d  = (qual || miss_q == MISS_TOP) ? '0 : miss_q + 1'b1;
               run_d   = '0;
            end
            default: state_d = SEARCH;
         endcase
      end
   end

   assign window_done      = done_q;
   assign zc_count_last    = zc_last_q;
   assign whistle_detected = det_q;
   assign whistle_active   = state_q == ACTIVE;
endmodule

// File: tb/tb_whistle_detector.sv
// tb_whistle_detector: random and directed windows checked against a per-window behavioural model.
module tb_whistle_detector;
   localparam int WIN    = 1024;
   localparam int ZC_MIN = 43;
   localparam int ZC_MAX = 128;
   localparam int HYST   = 256;
   localparam int HOLD   = 4;
   localparam int REL    = 2;
   localparam int AMP    = 2048;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               sample_valid = 1'b0;
   logic signed [15:0] sample_data = '0;
   logic               window_done;
   logic [10:0]        zc_count_last;
   logic               whistle_detected;
   logic               whistle_active;

   always #5 clk = ~clk;

   whistle_detector dut (
      .clk(clk),
      .rst(rst),
      .sample_valid(sample_valid),
      .sample_data(sample_data),
      .window_done(window_done),
      .zc_count_last(zc_count_last),
      .whistle_detected(whistle_detected),
      .whistle_active(whistle_active)
   );

   int n_chk, n_fail;
   bit m_sv, m_sign, m_active, e_det;
   int m_zc, m_cnt, m_peak, m_streak, m_miss, e_zc, g;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_sv = 0; m_sign = 0; m_active = 0; e_det = 0;
      m_zc = 0; m_cnt = 0; m_peak = 0; m_streak = 0; m_miss = 0; e_zc = 0;
   endtask

   task automatic model_sample(input int v, output bit closed);
      bit q;
      int mag;
      closed = 0;
      if (v > HYST || v < -HYST) begin
         if (m_sv && (v > HYST) != m_sign) m_zc++;
         m_sv   = 1;
         m_sign = v > HYST;
      end
      mag = v < 0 ? -v : v;
      if (mag > 32767) mag = 32767;
      if (mag > m_peak) m_peak = mag;
      m_cnt++;
      e_det = 0;
      if (m_cnt == WIN) begin
         closed = 1;
         e_zc   = m_zc;
         q      = m_zc >= ZC_MIN && m_zc <= ZC_MAX;
`ifdef WHISTLE_AMP_GATE_EN
         q      = q && m_peak >= AMP;
`endif
         if (!m_active) begin
            m_streak = q ? m_streak + 1 : 0;
            if (m_streak >= HOLD) begin
               m_active = 1; e_det = 1; m_miss = 0;
            end
         end else begin
            m_miss = q ? 0 : m_miss + 1;
            if (m_miss >= REL) begin
               m_active = 0; m_streak = 0;
            end
         end
         m_zc = 0; m_cnt = 0; m_peak = 0;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         sample_valid = 0;
         sample_data  = 16'($urandom);
         @(negedge clk);
         check("done_gap", window_done, 0);
         check("det_gap", whistle_detected, 0);
      end
   endtask

   task automatic push(input int v);
      bit closed;
      sample_valid = 1;
      sample_data  = 16'(v);
      model_sample(v, closed);
      @(negedge clk);
      sample_valid = 0;
      check(closed ? "done" : "done_mid", window_done, closed);
      check(closed ? "det" : "det_mid", whistle_detected, e_det);
      check("active", whistle_active, m_active);
      if (closed) check("zc", zc_count_last, e_zc);
   endtask

   // kind 0: square wave, 1: uniform noise in [-amp,amp], 2: exactly k sign flips then hold/deadband
   task automatic run_window(input int kind, input int amp, input int period, input int k, input int max_gap);
      int first;
      first = (m_sv && m_sign) ? -amp : amp;
      for (int i = 0; i < WIN; i++) begin
         int v;
         if (max_gap > 0 && $urandom_range(0, 3) == 0) idle($urandom_range(1, max_gap));
         if (kind == 0) v = ((g / (period / 2)) % 2) ? -amp : amp;
         else if (kind == 1) v = int'($urandom_range(0, 2 * amp)) - amp;
         else if (i < k) v = (i % 2) ? -first : first;
         else v = $urandom_range(0, 1) ? (((k - 1) % 2) ? -first : first)
                                       : int'($urandom_range(0, 2 * HYST)) - HYST;
         g++;
         push(v);
      end
   endtask

   initial begin
      int ks[6] = '{42, 43, 128, 129, 80, 43};
      n_chk = 0; n_fail = 0; g = 0;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 0;
      check("rst_done", window_done, 0);
      check("rst_det", whistle_detected, 0);
      check("rst_active", whistle_active, 0);
      check("rst_zc", zc_count_last, 0);

      repeat (4) run_window(0, 8000, 32, 0, 0);
      check("tone_active", whistle_active, 1);
      run_window(1, 0, 0, 0, 0);
      check("hold_one_miss", whistle_active, 1);
      run_window(1, 0, 0, 0, 0);
      check("released", whistle_active, 0);

      repeat (2) run_window(0, 8000, 128, 0, 0);
      repeat (3) run_window(0, 8000, 32, 0, 0);
      run_window(1, 0, 0, 0, 0);
      repeat (4) run_window(0, 8000, 32, 0, 0);
      repeat (2) run_window(1, 100, 0, 0, 0);
      check("noise_zc", zc_count_last, 0);

      repeat (4) run_window(0, 1000, 32, 0, 0);
`ifdef WHISTLE_AMP_GATE_EN
      check("amp_gate", whistle_active, 0);
`else
      check("amp_gate", whistle_active, 1);
`endif
      repeat (2) run_window(1, 0, 0, 0, 0);

      foreach (ks[i]) run_window(2, 5000, 0, ks[i], 0);

      repeat (6) begin
         case ($urandom_range(0, 2))
            0: run_window(0, $urandom_range(200, 9000), 2 * $urandom_range(4, 40), 0, 3);
            1: run_window(1, $urandom_range(0, 9000), 0, 0, 3);
            default: run_window(2, $urandom_range(300, 9000), 0, $urandom_range(30, 140), 3);
         endcase
      end

      repeat (4) run_window(0, 8000, 32, 0, 0);
      check("pre_rst_active", whistle_active, 1);
      repeat (500) begin
         push(((g / 16) % 2) ? -8000 : 8000);
         g++;
      end
      rst = 1;
      @(negedge clk);
      check("midrst_done", window_done, 0);
      check("midrst_det", whistle_detected, 0);
      check("midrst_active", whistle_active, 0);
      check("midrst_zc", zc_count_last, 0);
      rst = 0;
      model_reset();
      run_window(0, 8000, 32, 0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
